// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_pkg: shared types and default parameters for mem_arbiter       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_starve_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_starve_ctr: counts D grants made while I waits and forces an   |
// | I grant once STARVE_LIMIT is reached. Used under MEM_ARBITER_STARVE_GUARD_EN|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter_starve_ctr
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic grant_i_i,
  input  logic grant_d_i,
  output logic force_i_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_i_i) begin
      cnt_d = '0;
    end else if (grant_d_i) begin
      if (!i_req_i) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_i_o = (cnt_q == CNT_MAX) && i_req_i && d_req_i;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter: arbitrates an I-fetch port and a D port onto one memory port. |
// | Optional starvation guard: define MEM_ARBITER_STARVE_GUARD_EN.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  if (STARVE_LIMIT == 0) begin : g_limit_check
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  state_e            state_q, state_d;
  logic              gnt_instr, gnt_data, force_instr, mem_done;
  logic              mem_req_q, mem_we_q, i_ready_q, d_ready_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;

  always_comb begin
    state_d   = state_q;
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    mem_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_req && !force_instr) begin
          gnt_data = 1'b1;
          state_d  = ST_GRANT_D;
        end else if (i_req) begin
          gnt_instr = 1'b1;
          state_d   = ST_GRANT_I;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (mem_ready) begin
          mem_done = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      i_ready_q <= mem_done && (state_q == ST_GRANT_I);
      d_ready_q <= mem_done && (state_q == ST_GRANT_D);
      if (gnt_data) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= d_we;
        mem_addr_q  <= d_addr;
        mem_wdata_q <= d_wdata;
      end else if (gnt_instr) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= i_addr;
        mem_wdata_q <= '0;
      end else if (mem_done) begin
        mem_req_q   <= 1'b0;
      end
      if (mem_done && (state_q == ST_GRANT_I)) begin
        i_rdata_q <= mem_rdata;
      end
      // A completed D write must leave the last read value visible.
      if (mem_done && (state_q == ST_GRANT_D) && !mem_we_q) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  mem_arbiter_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req_i   (i_req),
    .d_req_i   (d_req),
    .grant_i_i (gnt_instr),
    .grant_d_i (gnt_data),
    .force_i_o (force_instr)
  );
`else
  assign force_instr = 1'b0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
